// File: rtl/seg_serial_adder_if.sv
// seg_serial_adder_if: operand and result handshakes
// for the segmented serial adder.
interface seg_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
endinterface

// File: rtl/seg_serial_adder.sv
// seg_serial_adder: WIDTH-bit add/sub resolved one
// SEG-bit segment per clock, LSB segment first.
module seg_serial_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 16
) (
  input logic              clk,
  input logic              rst,
  seg_serial_adder_if.slave bus
);
  localparam int NSEG = WIDTH / SEG;
  localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int SW   = SEG + 1;
  localparam logic [IW-1:0] LAST = IW'(NSEG - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             co_q;
  logic             ovf_q;

  logic [SEG-1:0]   seg_a;
  logic [SEG-1:0]   seg_b;
  logic [SEG:0]     seg_r;
  logic             capture;
  logic             step;
  logic             last;
  logic             release_q;

  assign capture   = (state == IDLE) && bus.in_valid;
  assign step      = (state == BUSY);
  assign last      = (idx == LAST);
  assign release_q = (state == DONE) && bus.out_ready;

  // pick the active operand segments for the narrow adder
  always_comb begin
    seg_a = '0;
    seg_b = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (idx == IW'(i)) begin
        seg_a = a_q[i*SEG +: SEG];
        seg_b = b_q[i*SEG +: SEG];
      end
    end
  end

  assign seg_r = {1'b0, seg_a}
               + {1'b0, seg_b}
               + SW'(carry);

  // sequencing: IDLE -> BUSY for NSEG cycles -> DONE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      unique case (1'b1)
        capture: begin
          state <= BUSY;
          idx   <= '0;
        end
        step: begin
          if (last) begin
            state <= DONE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        release_q: state <= IDLE;
        default: ;
      endcase
    end
  end

  // operand capture, segment accumulation and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      sum_q <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (capture) begin
      a_q   <= bus.a;
      b_q   <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.ci;
      sum_q <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (step) begin
      for (int i = 0; i < NSEG; i++) begin
        if (idx == IW'(i)) begin
          sum_q[i*SEG +: SEG] <= seg_r[SEG-1:0];
        end
      end
      carry <= seg_r[SEG];
      if (last) begin
        co_q  <= seg_r[SEG];
        ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1])
              && (seg_r[SEG-1] != a_q[WIDTH-1]);
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seg_serial_adder.sv
// tb_seg_serial_adder: three configurations (32/16,
// 48/16, 16/16) checked every cycle against a model.
module tb_seg_serial_adder;
  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic        sub;
    int          gap;
    int          hold;
  } op_t;

  typedef struct packed {
    logic        co;
    logic        ovf;
    logic [63:0] sum;
  } res_t;

  localparam int NRAND = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   go = 1'b0;
  bit   rst_hit = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  function automatic op_t mk(logic [63:0] a, logic [63:0] b,
                             logic ci, logic sub,
                             int gap, int hold);
    op_t o;
    o.a = a;
    o.b = b;
    o.ci = ci;
    o.sub = sub;
    o.gap = gap;
    o.hold = hold;
    return o;
  endfunction

  // plain w-bit arithmetic: sum mod 2^w, carry, signed overflow
  function automatic res_t ref_add(int w, logic [63:0] a,
                                   logic [63:0] b,
                                   logic ci, logic sub);
    logic [64:0] mask;
    logic [64:0] bb;
    logic [64:0] full;
    res_t r;
    mask = (65'd1 << w) - 65'd1;
    bb = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    full = ({1'b0, a} & mask) + bb + 65'(ci);
    r.sum = full[63:0] & mask[63:0];
    r.co = full[w];
    r.ovf = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W = (g == 0) ? 32 : (g == 1) ? 48 : 16;
    localparam int S = 16;
    localparam int NSEG = W / S;

    seg_serial_adder_if #(.WIDTH(W)) bus ();

    seg_serial_adder #(.WIDTH(W), .SEG(S)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    op_t  q[$];
    int   ii = 0;
    int   oi = 0;
    int   held = 0;
    bit   in_done = 1'b0;
    bit   pending = 1'b0;
    int   cyc = 0;
    int   cap = 0;
    res_t exp_r = '0;
    logic exp_ov;

    assign exp_ov = pending && (cyc > cap + NSEG);

    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        pending <= 1'b0;
      end else begin
        cyc <= cyc + 1;
        if (!pending) begin
          if (bus.in_valid) begin
            pending <= 1'b1;
            cap <= cyc;
            exp_r <= ref_add(W, 64'(bus.a), 64'(bus.b),
                             bus.ci, bus.sub);
          end
        end else if (cyc > cap + NSEG && bus.out_ready) begin
          pending <= 1'b0;
        end
      end
    end

    initial begin
      op_t o;
      int t;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.ci = 1'b0;
      bus.sub = 1'b0;
      q.push_back(mk(64'h1234_5678_9ABC, 64'hFFFF, 0, 0, 0, 0));
      if (g == 0) begin
        q.push_back(mk(64'd3, 64'd4, 0, 0, 0, 0));
        q.push_back(mk(64'hFFFF_FFFF, 64'd1, 0, 0, 1, 0));
        q.push_back(mk(64'd5, 64'd7, 1, 1, 0, 2));
        q.push_back(mk(64'd7, 64'd5, 1, 1, 0, 0));
        q.push_back(mk(64'h7FFF_FFFF, 64'd1, 0, 0, 0, 1));
        q.push_back(mk(64'h8000_0000, 64'd1, 1, 1, 0, 5));
        q.push_back(mk(64'hA5A5_A5A5, 64'h5A5A_5A5A, 1, 0, 0, 0));
      end else if (g == 1) begin
        q.push_back(mk(64'hFFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 0));
        q.push_back(mk(64'h8000_0000_0000, 64'd1, 1, 1, 0, 3));
      end else begin
        q.push_back(mk(64'hFFFF, 64'd1, 0, 0, 0, 0));
        q.push_back(mk(64'h7FFF, 64'd1, 0, 0, 0, 2));
      end
      repeat (NRAND) begin
        o = mk({$urandom(), $urandom()}, {$urandom(), $urandom()},
               1'($urandom()), 1'($urandom()),
               ($urandom_range(0, 3) == 0) ? 1 : 0,
               $urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) o.a = '1;
        q.push_back(o);
      end
      wait (go);
      while (ii < q.size()) begin
        @(negedge clk);
        if (q[ii].gap > 0) begin
          bus.in_valid = 1'b0;
          repeat (q[ii].gap) @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.a = W'(q[ii].a);
        bus.b = W'(q[ii].b);
        bus.ci = q[ii].ci;
        bus.sub = q[ii].sub;
        t = 0;
        do begin
          @(posedge clk);
          t++;
        end while (!(rst && bus.in_ready) && t < 200);
        ii++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      in_done = 1'b1;
    end

    initial begin
      int h;
      bus.out_ready = 1'b0;
      forever begin
        @(posedge clk or negedge clk or negedge rst);
        if (!rst) begin
          oi = ii;
          held = 0;
        end else if (clk) begin
          if (bus.out_valid && bus.out_ready) begin
            oi++;
            held = 0;
          end
        end else begin
          h = (oi < q.size()) ? q[oi].hold : 0;
          if (!bus.out_valid) begin
            bus.out_ready = (h == 0);
          end else begin
            bus.out_ready = (held >= h);
            held++;
          end
        end
      end
    end
  end

  // reset sequencing, including an abort during the first BUSY cycle
  initial begin
    rst = 1'b1;
    #7 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    go = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      if (cfg[0].bus.in_valid && cfg[0].bus.in_ready) begin
        rst_hit = 1'b1;
        break;
      end
    end
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  end

  task automatic chk(string nm, logic [67:0] act, logic [67:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp(string nm, logic ir, logic ov,
                     logic [63:0] sm, logic c, logic v,
                     logic eir, logic eov, res_t e);
    bit bad;
    vectors++;
    bad = (ir !== eir) || (ov !== eov);
    if (eov && ({c, v, sm} !== {e.co, e.ovf, e.sum})) bad = 1'b1;
    if (bad) begin
      miscompares++;
      $display("FAIL %s @%0t: in_ready=%b out_valid=%b sum=%h co=%b ovf=%b expected in_ready=%b out_valid=%b sum=%h co=%b ovf=%b",
               nm, $time, ir, ov, sm, c, v, eir, eov,
               e.sum, e.co, e.ovf);
    end
  endtask

  initial begin
    res_t r;
    bit fin;
    fin = 1'b0;
    r = ref_add(32, 64'hFFFF_FFFF, 64'd1, 0, 0);
    chk("lit_ffffffff_plus_1", 68'(r), 68'({1'b1, 1'b0, 64'h0}));
    r = ref_add(32, 64'd5, 64'd7, 1, 1);
    chk("lit_5_minus_7", 68'(r),
        68'({1'b0, 1'b0, 64'hFFFF_FFFE}));
    r = ref_add(32, 64'd7, 64'd5, 1, 1);
    chk("lit_7_minus_5", 68'(r), 68'({1'b1, 1'b0, 64'd2}));
    r = ref_add(32, 64'h7FFF_FFFF, 64'd1, 0, 0);
    chk("lit_pos_ovf", 68'(r),
        68'({1'b0, 1'b1, 64'h8000_0000}));
    r = ref_add(32, 64'h8000_0000, 64'd1, 1, 1);
    chk("lit_neg_ovf", 68'(r),
        68'({1'b1, 1'b1, 64'h7FFF_FFFF}));
    r = ref_add(32, 64'd3, 64'd4, 0, 0);
    chk("lit_3_plus_4", 68'(r), 68'({1'b0, 1'b0, 64'd7}));
    r = ref_add(48, 64'hFFFF_FFFF_FFFF, 64'd1, 0, 0);
    chk("lit_w48_wrap", 68'(r), 68'({1'b1, 1'b0, 64'h0}));
    r = ref_add(16, 64'hFFFF, 64'd1, 0, 0);
    chk("lit_w16_wrap", 68'(r), 68'({1'b1, 1'b0, 64'h0}));

    for (int t = 0; t < 60000 && !fin; t++) begin
      @(negedge clk or negedge rst);
      if (clk) begin
        #1;
        chk("rst_cfg0", {cfg[0].bus.in_ready, cfg[0].bus.out_valid,
                         cfg[0].bus.co, cfg[0].bus.ovf,
                         64'(cfg[0].bus.sum)},
            {1'b1, 1'b0, 1'b0, 1'b0, 64'h0});
        chk("rst_cfg1", {cfg[1].bus.in_ready, cfg[1].bus.out_valid,
                         cfg[1].bus.co, cfg[1].bus.ovf,
                         64'(cfg[1].bus.sum)},
            {1'b1, 1'b0, 1'b0, 1'b0, 64'h0});
        chk("rst_cfg2", {cfg[2].bus.in_ready, cfg[2].bus.out_valid,
                         cfg[2].bus.co, cfg[2].bus.ovf,
                         64'(cfg[2].bus.sum)},
            {1'b1, 1'b0, 1'b0, 1'b0, 64'h0});
      end else begin
        cmp("cfg0_w32", cfg[0].bus.in_ready, cfg[0].bus.out_valid,
            64'(cfg[0].bus.sum), cfg[0].bus.co, cfg[0].bus.ovf,
            !cfg[0].pending, cfg[0].exp_ov, cfg[0].exp_r);
        cmp("cfg1_w48", cfg[1].bus.in_ready, cfg[1].bus.out_valid,
            64'(cfg[1].bus.sum), cfg[1].bus.co, cfg[1].bus.ovf,
            !cfg[1].pending, cfg[1].exp_ov, cfg[1].exp_r);
        cmp("cfg2_w16", cfg[2].bus.in_ready, cfg[2].bus.out_valid,
            64'(cfg[2].bus.sum), cfg[2].bus.co, cfg[2].bus.ovf,
            !cfg[2].pending, cfg[2].exp_ov, cfg[2].exp_r);
        if (cfg[0].in_done && cfg[1].in_done && cfg[2].in_done
            && !cfg[0].pending && !cfg[1].pending
            && !cfg[2].pending) begin
          fin = 1'b1;
        end
      end
    end
    chk("run_complete", 68'(fin), 68'd1);
    chk("abort_capture_seen", 68'(rst_hit), 68'd1);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/seg_serial_adder.md
# seg_serial_adder

Parametrised multi-cycle adder/subtractor for the mul32 datapath. It generalises the fixed 16+1-bit adder into a WIDTH-bit add/sub unit that resolves the carry chain one SEG-bit segment per clock, LSB segment first. It accepts operands on a valid/ready handshake and returns the sum, carry-out and signed overflow on a held result handshake. It is the accumulation stage for partial products in the multiplier, with a narrow per-cycle adder and a registered carry between segments.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of SEG
- SEG, 16, bits resolved per cycle; NSEG = WIDTH/SEG (1 ≤ NSEG)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in
- sub  input  1  0: a+b+ci; 1: a+~b+ci (ci=1 gives a−b)
- out_valid  output  1  result held and valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, mod 2^WIDTH
- co  output  1  carry out of bit WIDTH−1
- ovf  output  1  signed overflow (operand sign bits equal after inversion, sum sign differs)

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, latch a, (sub ? ~b : b), ci into internal registers; clear segment index; go to BUSY.
- BUSY: each cycle add segment idx of A and B' plus the registered carry (ci for idx 0). Write SEG result bits into sum[idx*SEG +: SEG] and register the carry-out. Increment idx. After segment NSEG−1, compute co from the final carry and ovf from A[W−1], B'[W−1] and sum[W−1]. Go to DONE.
- DONE: out_valid=1. sum, co and ovf stay stable until out_ready. On out_valid&&out_ready go to IDLE.
- in_ready=0 in BUSY and DONE. in_valid is ignored there and operands are not sampled.
- No combinational path from out_ready to in_ready, or from in_valid to any output.
- sub inversion is applied once at capture. a/b/sub/ci changing after capture have no effect.
- Reset (rst=0, any state, including mid-BUSY): state→IDLE; sum=0, co=0, ovf=0, out_valid=0, idx=0, carry=0. in_ready=1 while in IDLE. An aborted operation produces no result.
- sum bits of segments not yet computed are don't-care while out_valid=0. They are cleared at capture.

## Timing
- Capture at edge k. BUSY occupies edges k+1 … k+NSEG. out_valid=1 from edge k+NSEG onward. Latency is NSEG cycles to result.
- Result consumed at edge m (out_valid&&out_ready). in_ready=1 from edge m. The next capture is at edge m+1 at the earliest.
- Peak throughput is one operation per NSEG+2 cycles.
- NSEG=1: BUSY lasts one cycle; latency is 1.
- Reset asserts outputs to reset values immediately (asynchronously). Release is synchronous to clk, and the first capture is possible at the first edge after deassertion.

## Test plan
- WIDTH=32, SEG=16: a=0xFFFF_FFFF, b=0x0000_0001, ci=0, sub=0 -> out_valid two cycles after capture, sum=0x0000_0000, co=1, ovf=0; the inter-segment carry is exercised.
- a=5, b=7, sub=1, ci=1 -> sum=0xFFFF_FFFE, co=0, ovf=0. a=7, b=5, sub=1, ci=1 -> sum=2, co=1.
- a=0x7FFF_FFFF, b=1, sub=0, ci=0 -> sum=0x8000_0000, co=0, ovf=1. a=0x8000_0000, b=1, sub=1, ci=1 -> sum=0x7FFF_FFFF, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while driving in_valid=1 with new operands -> sum/co/ovf stable, in_ready=0, no capture. Raise out_ready -> in_ready=1 next cycle, then the new operands are captured.
- Reset mid-operation: assert rst=0 during the first BUSY cycle -> out_valid=0, sum=0 immediately. After release, in_ready=1 and no result is emitted. A following add of 3+4 returns 7.
- Parameter sweep: WIDTH=48, SEG=16 -> latency 3, 0xFFFF_FFFF_FFFF+1 gives sum=0, co=1. WIDTH=SEG=16 -> latency 1. Run 1000 random operands per configuration against a reference model.
